sd_deser: RTL and testbench
===========================

SD_DESER -- requirements
Module: sd_deser

Interface
REQ-001 SHALL have parameter c_width, default 4: input beat width in bits, >=1.
REQ-002 SHALL have parameter beats, default 3: input beats per output word, >=2.
REQ-003 SHALL derive localparam p_width = c_width*beats and localparam cnt_sz = $clog2(beats).
REQ-004 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port c_srdy  input  1  consumer-side beat valid.
REQ-007 SHALL have port c_drdy  output  1  consumer-side beat ready.
REQ-008 SHALL have port c_data  input  c_width  narrow input beat.
REQ-009 SHALL have port p_srdy  output  1  producer-side word valid.
REQ-010 SHALL have port p_drdy  input  1  producer-side word ready.
REQ-011 SHALL have port p_data  output  p_width  assembled wide word.
REQ-012 SHALL have port beat_idx  output  cnt_sz  index of the next beat to be accepted.

Function
REQ-013 SHALL transfer a beat only on a clk edge with c_srdy=1 and c_drdy=1, and a word only with p_srdy=1 and p_drdy=1.
REQ-014 SHALL pack beats LSB-first: beat k occupies p_data[k*c_width +: c_width], k=0..beats-1.
REQ-015 SHALL keep beats 0..beats-2 in an assembly register and a beat counter 0..beats-1; beat_idx equals the counter.
REQ-016 SHALL increment the counter on each accepted beat and wrap beats-1 -> 0 on acceptance of the last beat.
REQ-017 SHALL drive c_drdy = (counter != beats-1) | ~p_srdy | p_drdy (combinational; no dependence on c_srdy).
REQ-018 SHALL, on acceptance of the last beat, load the output register with {c_data, assembly} and set p_srdy the next cycle (latency: 1 cycle after the last beat).
REQ-019 SHALL clear p_srdy on a word transfer unless a new last beat is accepted on the same edge, in which case p_srdy stays 1 and p_data updates.
REQ-020 SHALL hold p_data and p_srdy stable while p_srdy=1 and p_drdy=0.
REQ-021 SHALL sustain one beat per cycle with p_drdy=1 continuously (no bubbles; one word per beats cycles).
REQ-022 SHALL, with the output held (p_srdy=1, p_drdy=0), keep accepting beats 0..beats-2 and stall only the last beat.
REQ-023 SHALL leave the assembly register unchanged on cycles without a beat transfer; stale bits never alter a completed word.
REQ-024 SHALL never drop, duplicate or reorder beats or words.

Reset
REQ-025 SHALL, on any edge with reset=0, set counter=0, p_srdy=0, p_data=0 and assembly=0, overriding all transfers that cycle.
REQ-026 SHALL discard a partially assembled word and any unread output word when reset is asserted mid-operation.
REQ-027 SHALL drive c_drdy=1 in the first cycle after reset deasserts.

Verification (c_width=4, beats=3)
REQ-028 SHALL verify basic assembly: beats 0x1,0x2,0x3 on consecutive cycles with p_drdy=1 -> p_srdy=1 exactly one cycle after beat 0x3, p_data=0x321, beat_idx sequence 0,1,2,0.
REQ-029 SHALL verify backpressure: p_drdy=0 after word 0x321 -> beats 0x4,0x5 accepted, beat 0x6 sees c_drdy=0 until p_drdy=1; then p_data=0x654 follows 0x321.
REQ-030 SHALL verify simultaneous drain and fill: last beat accepted on the same edge as a word transfer -> p_srdy stays 1 with no idle cycle, next word is correct.
REQ-031 SHALL verify reset mid-word: beats 0xA,0xB accepted, reset=0 for 1 cycle -> beat_idx=0, p_srdy=0; beats 0x1,0x2,0x3 then give p_data=0x321.
REQ-032 SHALL verify a random run with sequential-count generator and checker under srdy/drdy patterns 0x5A/0xA5, 0xFD/0x03 and 0x11/0xEE -> at least 1000 words, zero mismatches.

Source files
------------

// File: rtl/sd_deser.sv
// Narrow-to-wide deserializer: collects `beats` input beats of c_width bits,
// packs them LSB-first and presents the assembled word on a registered output.
//
// Handshake: a beat moves on a rising clk edge where c_srdy && c_drdy, and a
// word moves on an edge where p_srdy && p_drdy. Sources hold data and valid
// until taken. c_drdy never looks at c_srdy, and p_srdy never looks at p_drdy.
module sd_deser #(
  parameter int c_width = 4,
  parameter int beats   = 3,
  localparam int p_width = c_width * beats,
  localparam int cnt_sz  = $clog2(beats)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                c_srdy,
  output logic                c_drdy,
  input  logic [c_width-1:0]  c_data,
  output logic                p_srdy,
  input  logic                p_drdy,
  output logic [p_width-1:0]  p_data,
  output logic [cnt_sz-1:0]   beat_idx
);

  localparam int a_width = c_width * (beats - 1);
  localparam logic [cnt_sz-1:0] last_idx = cnt_sz'(beats - 1);

  logic [cnt_sz-1:0]  cnt_q, cnt_d;
  logic [a_width-1:0] asm_q, asm_d;
  logic [p_width-1:0] p_data_q, p_data_d;
  logic               p_srdy_q, p_srdy_d;

  logic at_last, beat_xfer, word_xfer;

  // Only the last beat must wait for the output register to be free; it may
  // land on the same edge the held word leaves.
  assign at_last   = (cnt_q == last_idx);
  assign c_drdy    = !at_last || !p_srdy_q || p_drdy;
  assign beat_xfer = c_srdy && c_drdy;
  assign word_xfer = p_srdy_q && p_drdy;

  always_comb begin
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    p_data_d = p_data_q;
    p_srdy_d = p_srdy_q;
    if (word_xfer) begin
      p_srdy_d = 1'b0;
    end
    if (beat_xfer) begin
      if (at_last) begin
        cnt_d    = '0;
        p_data_d = {c_data, asm_q};
        p_srdy_d = 1'b1;
      end else begin
        cnt_d = cnt_q + cnt_sz'(1);
        for (int k = 0; k < beats - 1; k++) begin
          if (cnt_q == cnt_sz'(k)) begin
            asm_d[k*c_width +: c_width] = c_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      asm_q    <= '0;
      p_data_q <= '0;
      p_srdy_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
      p_data_q <= p_data_d;
      p_srdy_q <= p_srdy_d;
    end
  end

  assign p_srdy   = p_srdy_q;
  assign p_data   = p_data_q;
  assign beat_idx = cnt_q;

endmodule

// File: tb/tb_sd_deser.sv
// Bench for sd_deser (c_width=4, beats=3): directed vectors push expected words
// into a queue, and a negedge monitor pops and compares on every word transfer.
module tb_sd_deser;

  localparam int CW = 4;
  localparam int NB = 3;
  localparam int PW = CW * NB;

  logic          clk;
  logic          reset;
  logic          c_srdy;
  logic          c_drdy;
  logic [CW-1:0] c_data;
  logic          p_srdy;
  logic          p_drdy;
  logic [PW-1:0] p_data;
  logic [1:0]    beat_idx;

  logic [PW-1:0] exp_q[$];
  int checks;
  int errors;
  int words_seen;
  int cyc;

  sd_deser #(.c_width(CW), .beats(NB)) dut (
    .clk      (clk),
    .reset    (reset),
    .c_srdy   (c_srdy),
    .c_drdy   (c_drdy),
    .c_data   (c_data),
    .p_srdy   (p_srdy),
    .p_drdy   (p_drdy),
    .p_data   (p_data),
    .beat_idx (beat_idx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  logic          prev_hold;
  logic [PW-1:0] prev_data;
  initial begin
    prev_hold = 1'b0;
    prev_data = '0;
  end

  always @(negedge clk) begin
    if (reset) begin
      if (prev_hold) begin
        check("hold_srdy", {31'd0, p_srdy}, 32'd1);
        check("hold_data", {20'd0, p_data}, {20'd0, prev_data});
      end
      if (p_srdy && p_drdy) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_unexpected actual=%0h expected=none", p_data);
        end else begin
          check("word_data", {20'd0, p_data}, {20'd0, exp_q.pop_front()});
        end
      end
    end
    prev_hold = reset && p_srdy && !p_drdy;
    prev_data = p_data;
  end

  // drivers
  task automatic send_beat(input logic [CW-1:0] d, input int exp_idx);
    bit done;
    done   = 0;
    c_srdy = 1'b1;
    c_data = d;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (c_drdy) begin
        if (exp_idx >= 0) check("beat_idx", {30'd0, beat_idx}, exp_idx);
        done = 1;
      end
      @(posedge clk); #1;
    end
    c_srdy = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout actual=stalled expected=accepted");
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  logic [7:0]    s_pat [3];
  logic [7:0]    d_pat [3];
  logic [PW-1:0] mdl_word;
  int            mdl_k;
  logic [CW-1:0] seq;
  int            target;
  int            t0;

  initial begin
    checks = 0; errors = 0; words_seen = 0; cyc = 0;
    reset = 1'b0; c_srdy = 1'b0; c_data = '0; p_drdy = 1'b0;
    s_pat = '{8'h5A, 8'hFD, 8'h11};
    d_pat = '{8'hA5, 8'h03, 8'hEE};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_beat_idx", {30'd0, beat_idx}, 0);
    check("rst_p_srdy", {31'd0, p_srdy}, 0);
    check("rst_p_data", {20'd0, p_data}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_c_drdy", {31'd0, c_drdy}, 1);
    @(posedge clk); #1;

    // basic assembly, 1-cycle latency
    p_drdy = 1'b1;
    exp_q.push_back(12'h321);
    send_beat(4'h1, 0);
    send_beat(4'h2, 1);
    check("basic_not_early", {31'd0, p_srdy}, 0);
    send_beat(4'h3, 2);
    check("basic_latency", {31'd0, p_srdy}, 1);
    check("basic_data", {20'd0, p_data}, 32'h321);
    check("basic_idx_wrap", {30'd0, beat_idx}, 0);
    idle(1);
    check("basic_drained", {31'd0, p_srdy}, 0);

    // backpressure, then drain and fill on the same edge
    p_drdy = 1'b0;
    exp_q.push_back(12'h321);
    send_beat(4'h1, 0);
    send_beat(4'h2, 1);
    send_beat(4'h3, 2);
    exp_q.push_back(12'h654);
    send_beat(4'h4, 0);
    send_beat(4'h5, 1);
    check("bp_held", {31'd0, p_srdy}, 1);
    c_srdy = 1'b1;
    c_data = 4'h6;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall_last", {31'd0, c_drdy}, 0);
      check("bp_data_held", {20'd0, p_data}, 32'h321);
      @(posedge clk); #1;
    end
    p_drdy = 1'b1;
    @(negedge clk);
    check("bp_release", {31'd0, c_drdy}, 1);
    @(posedge clk); #1;
    c_srdy = 1'b0;
    check("df_no_idle", {31'd0, p_srdy}, 1);
    check("df_next_word", {20'd0, p_data}, 32'h654);
    idle(1);
    check("df_drained", {31'd0, p_srdy}, 0);

    // full throughput: six beats in six cycles
    exp_q.push_back(12'h987);
    exp_q.push_back(12'hCBA);
    t0 = cyc;
    send_beat(4'h7, 0);
    send_beat(4'h8, 1);
    send_beat(4'h9, 2);
    send_beat(4'hA, 0);
    send_beat(4'hB, 1);
    send_beat(4'hC, 2);
    check("throughput_cycles", cyc - t0, 6);
    idle(2);

    // reset mid-word
    send_beat(4'hA, 0);
    send_beat(4'hB, 1);
    do_reset();
    check("midrst_idx", {30'd0, beat_idx}, 0);
    check("midrst_srdy", {31'd0, p_srdy}, 0);
    check("midrst_c_drdy", {31'd0, c_drdy}, 1);
    exp_q.push_back(12'h321);
    send_beat(4'h1, 0);
    send_beat(4'h2, 1);
    send_beat(4'h3, 2);
    idle(2);

    // reset discards an unread word
    p_drdy = 1'b0;
    exp_q.push_back(12'hEDF);
    send_beat(4'hF, 0);
    send_beat(4'hD, 1);
    send_beat(4'hE, 2);
    check("unread_held", {31'd0, p_srdy}, 1);
    do_reset();
    check("unread_gone_srdy", {31'd0, p_srdy}, 0);
    check("unread_gone_data", {20'd0, p_data}, 0);
    p_drdy = 1'b1;
    idle(2);

    // sequential-count stream under fixed srdy/drdy patterns
    seq = '0;
    mdl_k = 0;
    mdl_word = '0;
    for (int p = 0; p < 3; p++) begin
      target = words_seen + 340;
      for (int n = 0; n < 20000 && words_seen < target; n++) begin
        c_srdy = s_pat[p][n % 8];
        p_drdy = d_pat[p][n % 8];
        c_data = seq;
        @(negedge clk);
        if (c_srdy && c_drdy) begin
          mdl_word[mdl_k*CW +: CW] = seq;
          seq = seq + 4'd1;
          if (mdl_k == NB - 1) begin
            exp_q.push_back(mdl_word);
            mdl_k = 0;
          end else begin
            mdl_k++;
          end
        end
        @(posedge clk); #1;
      end
      checks++;
      if (words_seen < target) begin
        errors++;
        $display("FAIL stream_timeout actual=%0d expected=%0d", words_seen, target);
      end
    end
    c_srdy = 1'b0;
    p_drdy = 1'b1;
    idle(6);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
